// File: rtl/alu_ctrl_pkg.sv
// ALU control shared definitions: ALU codes, funct and class codes,
// and the mult/div sequencer state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULT  = 4'b1101;
  localparam logic [3:0] ALU_MULTU = 4'b1110;
  localparam logic [3:0] ALU_DIV   = 4'b1111;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;
  localparam logic [2:0] AOP_AND   = 3'b011;
  localparam logic [2:0] AOP_OR    = 3'b100;
  localparam logic [2:0] AOP_SLT   = 3'b101;
  localparam logic [2:0] AOP_XOR   = 3'b110;
  localparam logic [2:0] AOP_LUI   = 3'b111;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_seq_counter.sv
// Mult/div occupancy sequencer: launches a pulse and holds busy/stall
// for a fixed cycle count chosen by operation kind.
module md_seq_counter
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic md_start,
  output logic md_busy,
  output logic stall
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

  md_state_e state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      md_start <= 1'b0;
      md_busy  <= 1'b0;
      stall    <= 1'b0;
    end else begin
      md_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= MD_RUN;
            cnt      <= is_div ? DIV_LD : MUL_LD;
            md_start <= 1'b1;
            md_busy  <= 1'b1;
            stall    <= 1'b1;
          end
        end
        MD_RUN: begin
          // busy spans the load edge plus cnt further edges
          if (cnt == '0) begin
            state   <= IDLE;
            md_busy <= 1'b0;
            stall   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with jr pulse, HI/LO select and
// mult/div sequencing that stalls upstream while the unit is busy.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 3,
  parameter int FUNCT_W    = 6,
  parameter int SIG_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               Clk,
  input  logic               Rst_N,
  input  logic               Valid_In,
  input  logic [ALUOP_W-1:0] Alu_OP,
  input  logic [FUNCT_W-1:0] Inst_5_0,
  output logic [SIG_W-1:0]   Alu_Signal,
  output logic               Valid_Out,
  output logic               JR_Signal,
  output logic [1:0]         Hilo_Sel,
  output logic               MD_Start,
  output logic               MD_Busy,
  output logic               Stall,
  output logic               Illegal
);

  logic       accept;
  logic [3:0] dec_sig;
  logic [1:0] dec_hilo;
  logic       dec_jr;
  logic       dec_md;
  logic       dec_div;
  logic       dec_ill;

  assign accept = Valid_In & ~Stall;

  always_comb begin
    dec_sig  = ALU_ADD;
    dec_hilo = HILO_NONE;
    dec_jr   = 1'b0;
    dec_md   = 1'b0;
    dec_div  = 1'b0;
    dec_ill  = 1'b0;
    case (Alu_OP)
      ALUOP_W'(AOP_ADD): dec_sig = ALU_ADD;
      ALUOP_W'(AOP_SUB): dec_sig = ALU_SUB;
      ALUOP_W'(AOP_AND): dec_sig = ALU_AND;
      ALUOP_W'(AOP_OR):  dec_sig = ALU_OR;
      ALUOP_W'(AOP_SLT): dec_sig = ALU_SLT;
      ALUOP_W'(AOP_XOR): dec_sig = ALU_XOR;
      ALUOP_W'(AOP_LUI): dec_sig = ALU_LUI;
      ALUOP_W'(AOP_RTYPE): begin
        case (Inst_5_0)
          FUNCT_W'(F_ADD):  dec_sig = ALU_ADD;
          FUNCT_W'(F_SUB):  dec_sig = ALU_SUB;
          FUNCT_W'(F_AND):  dec_sig = ALU_AND;
          FUNCT_W'(F_OR):   dec_sig = ALU_OR;
          FUNCT_W'(F_SLT):  dec_sig = ALU_SLT;
          FUNCT_W'(F_XOR):  dec_sig = ALU_XOR;
          FUNCT_W'(F_NOR):  dec_sig = ALU_NOR;
          FUNCT_W'(F_SLL):  dec_sig = ALU_SLL;
          FUNCT_W'(F_SRL):  dec_sig = ALU_SRL;
          FUNCT_W'(F_SRA):  dec_sig = ALU_SRA;
          FUNCT_W'(F_MULT): begin
            dec_sig = ALU_MULT;
            dec_md  = 1'b1;
          end
          FUNCT_W'(F_MULTU): begin
            dec_sig = ALU_MULTU;
            dec_md  = 1'b1;
          end
          FUNCT_W'(F_DIV): begin
            dec_sig = ALU_DIV;
            dec_md  = 1'b1;
            dec_div = 1'b1;
          end
          FUNCT_W'(F_DIVU): begin
            dec_sig = ALU_DIVU;
            dec_md  = 1'b1;
            dec_div = 1'b1;
          end
          FUNCT_W'(F_MFHI): dec_hilo = HILO_HI;
          FUNCT_W'(F_MFLO): dec_hilo = HILO_LO;
          FUNCT_W'(F_JR):   dec_jr = 1'b1;
          default:          dec_ill = 1'b1;
        endcase
      end
      default: dec_sig = ALU_ADD;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      Alu_Signal <= '0;
      Valid_Out  <= 1'b0;
      JR_Signal  <= 1'b0;
      Hilo_Sel   <= HILO_NONE;
      Illegal    <= 1'b0;
    end else begin
      Valid_Out <= accept;
      JR_Signal <= accept & dec_jr;
      Illegal   <= accept & dec_ill;
      // jr keeps the previous ALU code; illegal keeps code and select
      if (accept && !dec_ill) begin
        Hilo_Sel <= dec_hilo;
        if (!dec_jr) Alu_Signal <= SIG_W'(dec_sig);
      end
    end
  end

  md_seq_counter #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md (
    .clk     (Clk),
    .rst_n   (Rst_N),
    .start   (accept & dec_md),
    .is_div  (dec_div),
    .md_start(MD_Start),
    .md_busy (MD_Busy),
    .stall   (Stall)
  );

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomised and directed bench for alu_control_seq against a
// table-driven model that tracks remaining busy cycles.
module tb_alu_control_seq;

  localparam int MULC = 4;
  localparam int DIVC = 32;

  logic       Clk = 1'b0;
  logic       Rst_N;
  logic       Valid_In;
  logic [2:0] Alu_OP;
  logic [5:0] Inst_5_0;
  logic [3:0] Alu_Signal;
  logic       Valid_Out;
  logic       JR_Signal;
  logic [1:0] Hilo_Sel;
  logic       MD_Start;
  logic       MD_Busy;
  logic       Stall;
  logic       Illegal;

  int checks = 0;
  int errors = 0;

  int fcode[64];
  int aop_code[8];
  logic [5:0] flist[17];

  int         m_rem;
  logic [3:0] m_sig;
  logic [1:0] m_hilo;
  logic       m_vout, m_jr, m_ill, m_start;

  alu_control_seq #(
    .ALUOP_W(3), .FUNCT_W(6), .SIG_W(4),
    .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)
  ) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Valid_In(Valid_In),
    .Alu_OP(Alu_OP), .Inst_5_0(Inst_5_0),
    .Alu_Signal(Alu_Signal), .Valid_Out(Valid_Out),
    .JR_Signal(JR_Signal), .Hilo_Sel(Hilo_Sel),
    .MD_Start(MD_Start), .MD_Busy(MD_Busy),
    .Stall(Stall), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_sig = 4'h0; m_hilo = 2'b00;
    m_vout = 0; m_jr = 0; m_ill = 0; m_start = 0;
  endtask

  task automatic model_next(input logic v, input logic [2:0] op,
                            input logic [5:0] f);
    bit acc;
    acc = v && (m_rem == 0);
    m_vout = acc; m_jr = 0; m_ill = 0; m_start = 0;
    if (m_rem > 0) m_rem--;
    if (acc) begin
      if (op != 3'd2) begin
        m_sig = 4'(aop_code[op]);
        m_hilo = 2'b00;
      end else if (f == 6'h08) begin
        m_jr = 1;
        m_hilo = 2'b00;
      end else if (fcode[f] < 0) begin
        m_ill = 1;
      end else begin
        m_sig = 4'(fcode[f]);
        m_hilo = (f == 6'h10) ? 2'b01 : (f == 6'h12) ? 2'b10 : 2'b00;
        if (f >= 6'h18 && f <= 6'h1b) begin
          m_start = 1;
          m_rem = (f >= 6'h1a) ? DIVC : MULC;
        end
      end
    end
  endtask

  task automatic compare();
    chk("alu_signal", 32'(Alu_Signal), 32'(m_sig));
    chk("valid_out", 32'(Valid_Out), 32'(m_vout));
    chk("jr_signal", 32'(JR_Signal), 32'(m_jr));
    chk("hilo_sel", 32'(Hilo_Sel), 32'(m_hilo));
    chk("md_start", 32'(MD_Start), 32'(m_start));
    chk("md_busy", 32'(MD_Busy), 32'(m_rem > 0));
    chk("stall", 32'(Stall), 32'(m_rem > 0));
    chk("illegal", 32'(Illegal), 32'(m_ill));
  endtask

  task automatic step(input logic v, input logic [2:0] op,
                      input logic [5:0] f);
    Valid_In = v; Alu_OP = op; Inst_5_0 = f;
    model_next(v, op, f);
    @(posedge Clk);
    #1;
    compare();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (Stall && g < 200) begin
      step(1'b0, 3'd0, 6'd0);
      g++;
    end
    chk("stall_bound", 32'(Stall), 32'd0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 64; i++) fcode[i] = -1;
    fcode[6'h20] = 2;  fcode[6'h22] = 6;  fcode[6'h24] = 0;
    fcode[6'h25] = 1;  fcode[6'h2a] = 7;  fcode[6'h26] = 3;
    fcode[6'h27] = 12; fcode[6'h00] = 4;  fcode[6'h02] = 8;
    fcode[6'h03] = 9;  fcode[6'h18] = 13; fcode[6'h19] = 14;
    fcode[6'h1a] = 15; fcode[6'h1b] = 11; fcode[6'h10] = 2;
    fcode[6'h12] = 2;
    aop_code = '{2, 6, 0, 0, 1, 7, 3, 10};
    flist = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h26, 6'h27, 6'h00,
              6'h02, 6'h03, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12,
              6'h08};

    Rst_N = 1'b0; Valid_In = 1'b0; Alu_OP = 3'd0; Inst_5_0 = 6'd0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    compare();
    chk("rst_sig", 32'(Alu_Signal), 32'd0);
    Rst_N = 1'b1;

    // add class, then an idle cycle
    step(1'b1, 3'd0, 6'd0);
    chk("t1_sig", 32'(Alu_Signal), 32'h2);
    chk("t1_vout", 32'(Valid_Out), 32'd1);
    step(1'b0, 3'd0, 6'd0);
    chk("t1_idle_vout", 32'(Valid_Out), 32'd0);
    chk("t1_hold", 32'(Alu_Signal), 32'h2);

    // funct sweep
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 3'd2, flist[i]);
      wait_idle();
    end
    step(1'b1, 3'd2, 6'h10);
    chk("t2_mfhi", 32'(Hilo_Sel), 32'd1);
    step(1'b1, 3'd2, 6'h12);
    chk("t2_mflo", 32'(Hilo_Sel), 32'd2);
    step(1'b1, 3'd2, 6'h27);
    chk("t2_nor", 32'(Alu_Signal), 32'hc);
    chk("t2_nor_hilo", 32'(Hilo_Sel), 32'd0);

    // jr keeps previous code
    step(1'b1, 3'd1, 6'd0);
    step(1'b1, 3'd2, 6'h08);
    chk("t3_jr", 32'(JR_Signal), 32'd1);
    chk("t3_sig", 32'(Alu_Signal), 32'h6);
    step(1'b0, 3'd0, 6'd0);
    chk("t3_jr_off", 32'(JR_Signal), 32'd0);

    // mult with add held behind it
    step(1'b1, 3'd2, 6'h18);
    chk("t4_start", 32'(MD_Start), 32'd1);
    cnt = 0;
    while (Stall && cnt < 100) begin
      cnt++;
      step(1'b1, 3'd2, 6'h20);
      chk("t4_sig_hold", 32'(Alu_Signal), (Stall || cnt < MULC) ? 32'hd : 32'hd);
    end
    chk("t4_mul_stall", 32'(cnt), 32'd4);
    step(1'b1, 3'd2, 6'h20);
    chk("t4_add", 32'(Alu_Signal), 32'h2);
    chk("t4_add_v", 32'(Valid_Out), 32'd1);

    step(1'b1, 3'd2, 6'h1a);
    cnt = 0;
    while (Stall && cnt < 100) begin
      cnt++;
      step(1'b1, 3'd2, 6'h20);
    end
    chk("t4_div_stall", 32'(cnt), 32'd32);

    // undefined funct
    step(1'b1, 3'd2, 6'h12);
    step(1'b1, 3'd2, 6'h3f);
    chk("t5_ill", 32'(Illegal), 32'd1);
    chk("t5_vout", 32'(Valid_Out), 32'd1);
    chk("t5_sig", 32'(Alu_Signal), 32'h2);
    chk("t5_hilo", 32'(Hilo_Sel), 32'd2);
    chk("t5_busy", 32'(MD_Busy), 32'd0);

    // async reset mid-div
    step(1'b1, 3'd2, 6'h1a);
    repeat (9) step(1'b0, 3'd0, 6'd0);
    #2;
    Rst_N = 1'b0;
    #1;
    model_reset();
    chk("t6_sig", 32'(Alu_Signal), 32'd0);
    chk("t6_busy", 32'(MD_Busy), 32'd0);
    chk("t6_stall", 32'(Stall), 32'd0);
    chk("t6_hilo", 32'(Hilo_Sel), 32'd0);
    compare();
    @(posedge Clk);
    #1;
    Rst_N = 1'b1;
    compare();
    step(1'b1, 3'd1, 6'd0);
    chk("t6_sub", 32'(Alu_Signal), 32'h6);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic v;
      logic [2:0] op;
      logic [5:0] f;
      v = ($urandom_range(0, 9) < 7);
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) f = 6'($urandom_range(0, 63));
      else f = flist[$urandom_range(0, 16)];
      if (op != 3'd2 && $urandom_range(0, 1) == 0) op = 3'd2;
      step(v, op, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
Clocked, parametrised successor to the combinational ALU control decoder. It registers the ALU control code and replaces the delay-based JR pulse with a clean one-cycle pulse. It adds multi-cycle mult/div sequencing with a pipeline stall and HI/LO read-select decoding. It sits between the main control unit (Alu_OP) and the ALU / mul-div unit, with one cycle of decode latency.

Parameters:
ALUOP_W, 3, width of Alu_OP from the control unit
FUNCT_W, 6, width of the funct field
SIG_W, 4, width of Alu_Signal; codes are zero-extended when SIG_W > 4; minimum 4
MUL_CYCLES, 4, busy cycles for mult/multu; minimum 1
DIV_CYCLES, 32, busy cycles for div/divu; minimum 1

Ports:
Clk  in  1  clock, rising edge
Rst_N  in  1  asynchronous active-low reset
Valid_In  in  1  Alu_OP/Inst_5_0 carry a new instruction this cycle
Alu_OP  in  ALUOP_W  class code from the control unit
Inst_5_0  in  FUNCT_W  funct field
Alu_Signal  out  SIG_W  registered ALU operation code
Valid_Out  out  1  Alu_Signal/Hilo_Sel are valid for the decoded instruction
JR_Signal  out  1  one-cycle pulse for jr
Hilo_Sel  out  2  00 none, 01 HI (mfhi), 10 LO (mflo)
MD_Start  out  1  one-cycle pulse launching mult/div
MD_Busy  out  1  mul/div unit occupied
Stall  out  1  upstream must hold its instruction; Valid_In is ignored while high
Illegal  out  1  one-cycle pulse: undefined funct under R-format

Behaviour:
- Reset (asynchronous, Rst_N low): Alu_Signal=0, Valid_Out=0, JR_Signal=0, Hilo_Sel=00, MD_Start=0, MD_Busy=0, Stall=0, Illegal=0, FSM=IDLE, counter=0. Deassertion takes effect at the next edge.
- Alu_OP decode:
  - 000 -> 0010
  - 001 -> 0110
  - 011 -> 0000
  - 100 -> 0001
  - 101 -> 0111
  - 110 -> 0011
  - 111 -> 1010
  - 010 -> funct decode
- Funct decode (Alu_OP=010):
  - add 100000 -> 0010; sub 100010 -> 0110; and 100100 -> 0000; or 100101 -> 0001
  - slt 101010 -> 0111; xor 100110 -> 0011; nor 100111 -> 1100
  - sll 000000 -> 0100; srl 000010 -> 1000; sra 000011 -> 1001
  - mult 011000 -> 1101; multu 011001 -> 1110; div 011010 -> 1111; divu 011011 -> 1011
  - mfhi 010000 -> 0010 with Hilo_Sel=01; mflo 010010 -> 0010 with Hilo_Sel=10
  - jr 001000 -> JR_Signal=1 for exactly one cycle; Alu_Signal holds its previous value
- Latency: an accepted input (Valid_In & !Stall) updates the outputs on the next rising edge. Valid_Out=1 for that one cycle, otherwise 0.
- Pulse outputs: JR_Signal, MD_Start and Illegal are single-cycle pulses aligned with Valid_Out.
- Hilo_Sel: returns to 00 on any non-mfhi/mflo accept. It holds its value when no instruction is accepted.
- Undefined funct under R-format:
  - Illegal pulses and Valid_Out=1.
  - Alu_Signal and Hilo_Sel hold their previous values.
  - No JR or MD activity.
- FSM states: IDLE, MD_RUN.
  - IDLE -> MD_RUN on an accepted mult/multu/div/divu. MD_Start pulses, MD_Busy=1, Stall=1.
  - The counter loads MUL_CYCLES-1 for mult/multu or DIV_CYCLES-1 for div/divu, and decrements each cycle in MD_RUN.
  - MD_RUN -> IDLE on the edge where the counter equals 0. MD_Busy and Stall drop together on that edge.
  - Total MD_Busy high time: MUL_CYCLES or DIV_CYCLES cycles.
  - Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- While Stall=1:
  - Valid_In is ignored and no outputs change except the counter and FSM.
  - Alu_Signal holds the mult/div code.
- Back-to-back: an instruction presented on the cycle Stall drops is accepted on that edge.
- mfhi/mflo while MD_Busy: cannot occur because of Stall. No extra hazard logic is required.
- Reset mid-operation aborts MD_RUN immediately (async): MD_Busy=0, Stall=0.
- No combinational path from inputs to outputs. All outputs are registers.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the ALU code localparams (ALU_ADD=0010, ALU_SUB=0110, … ALU_DIVU=1011);
  - the funct constants (F_ADD, F_JR, F_MULT, …);
  - the ALUOP class constants;
  - the FSM state enum.
- Sub-module md_seq_counter contains the IDLE/MD_RUN FSM, counter, MD_Start/MD_Busy/Stall. Inputs: start, is_div. The top module keeps the decode and output registers.

Test Plan:
1. Reset then Alu_OP=000 with Valid_In=1 -> next edge Alu_Signal=0010, Valid_Out=1; following idle cycle Valid_Out=0 and Alu_Signal held.
2. Alu_OP=010 with funct sweep across all 16 defined functs -> codes per table; mfhi gives Hilo_Sel=01, mflo gives 10, add gives 00.
3. Alu_OP=010, funct=001000 -> JR_Signal high exactly 1 cycle; Alu_Signal unchanged from the prior instruction.
4. mult (MUL_CYCLES=4) followed immediately by add held on the inputs -> MD_Start 1 cycle, Stall high exactly 4 cycles; add accepted on the edge Stall drops and Alu_Signal=0010 one cycle later. div with DIV_CYCLES=32 -> Stall high exactly 32 cycles.
5. Alu_OP=010, funct=111111 -> Illegal 1-cycle pulse, Valid_Out=1, Alu_Signal and Hilo_Sel unchanged, MD_Busy=0.
6. Assert Rst_N=0 mid-edge during cycle 10 of a div -> all outputs 0 immediately without a clock edge; after release, sub is accepted normally and yields 0110.
